// File: rtl/sha256_defs.sv
// Shared constants for the SHA-256 nonce feeder: IV, FSM encodings and padding fields.
package sha256_defs;

   localparam logic [255:0] SHA256_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD1 = 3'd1;
   localparam logic [2:0] ST_WAIT1 = 3'd2;
   localparam logic [2:0] ST_LOAD2 = 3'd3;
   localparam logic [2:0] ST_WAIT2 = 3'd4;
   localparam logic [2:0] ST_CHECK = 3'd5;

   localparam logic [7:0] PAD_BYTE = 8'h80;
   localparam int         LEN_HDR  = 640;
   localparam int         LEN_HASH = 256;

   // Bytes 62..63 of the final block carry the bit length big-endian.
   function automatic logic [15:0] len_field(input logic [15:0] bits);
      return {bits[7:0], bits[15:8]};
   endfunction

endpackage

// File: rtl/sha256_word_bswap.sv
// Reverses the byte order inside each of the eight 32-bit words of a 256-bit digest.
module sha256_word_bswap (
   input  logic [255:0] words,
   output logic [255:0] swapped
);

   for (genvar k = 0; k < 8; k++) begin : g_word
      for (genvar j = 0; j < 4; j++) begin : g_byte
         assign swapped[32*k + 8*j +: 8] = words[32*k + 8*(3-j) +: 8];
      end
   end

endmodule

// File: rtl/sha256_nonce_feeder.sv
// Nonce sequencer driving an external sha256_chunk through two passes per nonce.
// Define SHA_FEEDER_TARGET_EN to add a 256-bit target port and a full digest compare.
module sha256_nonce_feeder
   import sha256_defs::*;
#(
   parameter int CHUNK_LAT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         work_valid,
   output logic         work_ready,
   input  logic [255:0] midstate,
   input  logic [95:0]  hdr_tail,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic         abort,
`ifdef SHA_FEEDER_TARGET_EN
   input  logic [255:0] target,
`endif
   output logic [511:0] core_data,
   output logic [255:0] core_V,
   output logic         core_start,
   input  logic [255:0] core_hash,
   output logic         result_valid,
   output logic [31:0]  result_nonce,
   output logic         busy,
   output logic         done
);

   localparam int CW = (CHUNK_LAT > 1) ? $clog2(CHUNK_LAT) : 1;
`ifdef SHA_FEEDER_TARGET_EN
   localparam int H2W = 256;
`else
   localparam int H2W = 32;
`endif

   logic [2:0]     state;
   logic [255:0]   mid_q;
   logic [95:0]    tail_q;
   logic [31:0]    end_q;
   logic [31:0]    nonce;
   logic [255:0]   h1;
   logic [H2W-1:0] h2;
   logic [CW-1:0]  cnt;
   logic [255:0]   h1_sw;
   logic [511:0]   hdr_blk;
   logic [511:0]   hash_blk;
   logic           wait_last;
   logic           hit;

   sha256_word_bswap u_h1_bswap (.words(h1), .swapped(h1_sw));

`ifdef SHA_FEEDER_TARGET_EN
   logic [255:0] h2_sw;
   sha256_word_bswap u_h2_bswap (.words(h2), .swapped(h2_sw));
   assign hit = (h2_sw <= target);
`else
   // Only H7 is kept for the default compare.
   assign hit = (h2 == '0);
`endif

   assign hdr_blk   = {len_field(16'(LEN_HDR)), 360'b0, PAD_BYTE, nonce, tail_q};
   assign hash_blk  = {len_field(16'(LEN_HASH)), 232'b0, PAD_BYTE, h1_sw};
   assign wait_last = (cnt == CW'(CHUNK_LAT - 1));
   assign work_ready = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         mid_q        <= '0;
         tail_q       <= '0;
         end_q        <= '0;
         nonce        <= '0;
         h1           <= '0;
         h2           <= '0;
         cnt          <= '0;
         core_data    <= '0;
         core_V       <= '0;
         core_start   <= 1'b0;
         result_valid <= 1'b0;
         result_nonce <= '0;
         done         <= 1'b0;
      end else begin
         core_start   <= 1'b0;
         result_valid <= 1'b0;
         done         <= 1'b0;
         // Abort outranks everything, including a hit being reported in CHECK.
         if (abort && state != ST_IDLE) begin
            state <= ST_IDLE;
            done  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: if (work_valid) begin
                  mid_q  <= midstate;
                  tail_q <= hdr_tail;
                  end_q  <= nonce_end;
                  nonce  <= nonce_start;
                  state  <= ST_LOAD1;
               end
               ST_LOAD1: begin
                  core_V     <= mid_q;
                  core_data  <= hdr_blk;
                  core_start <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_WAIT1;
               end
               ST_WAIT1: if (wait_last) begin
                  h1    <= core_hash;
                  state <= ST_LOAD2;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               ST_LOAD2: begin
                  core_V     <= SHA256_IV;
                  core_data  <= hash_blk;
                  core_start <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_WAIT2;
               end
               ST_WAIT2: if (wait_last) begin
                  h2    <= core_hash[255 -: H2W];
                  state <= ST_CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               ST_CHECK: begin
                  if (hit) begin
                     result_valid <= 1'b1;
                     result_nonce <= nonce;
                  end
                  if (nonce == end_q) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     nonce <= nonce + 32'd1;
                     state <= ST_LOAD1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// Bench for sha256_nonce_feeder with a behavioural sha256_chunk and a scoreboard model.
module tb_sha256_nonce_feeder;

   localparam int LAT       = 64;
   localparam int NONCE_CYC = 2*LAT + 3;
   localparam logic [31:0] GEN_NONCE = 32'h7C2BAC1D;
   localparam logic [255:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   // Genesis block header, bytes in wire order (byte 0 leftmost).
   localparam logic [639:0] GEN_HDR = 640'h01000000_0000000000000000_0000000000000000_0000000000000000_0000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;

   typedef struct packed { logic [511:0] d; logic [255:0] v; } core_t;

   logic         clk = 1'b0;
   logic         reset, work_valid, work_ready, abort, core_start;
   logic         result_valid, busy, done;
   logic [255:0] midstate, core_V, target;
   logic [255:0] core_hash = '0;
   logic [95:0]  hdr_tail;
   logic [31:0]  nonce_start, nonce_end, result_nonce;
   logic [511:0] core_data;

   int n_chk = 0, n_fail = 0, cyc = 0, acc = 0;
   int done_cnt = 0, done_cyc = 0, rv_cnt = 0, rv_cyc = 0, cs_cnt = 0, n_hits = 0;
   logic [31:0]  last_nonce = '0;
   logic [255:0] mid_m, pend;
   logic [95:0]  tail_m;
   int           lat = 0;
   core_t        exp_core[$];
   logic [31:0]  exp_res[$];

   sha256_nonce_feeder #(.CHUNK_LAT(LAT)) dut (
`ifdef SHA_FEEDER_TARGET_EN
      .target(target),
`endif
      .clk(clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
      .midstate(midstate), .hdr_tail(hdr_tail), .nonce_start(nonce_start),
      .nonce_end(nonce_end), .abort(abort), .core_data(core_data), .core_V(core_V),
      .core_start(core_start), .core_hash(core_hash), .result_valid(result_valid),
      .result_nonce(result_nonce), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [511:0] blk, input logic [255:0] v);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++)
         w[t] = {blk[32*t +: 8], blk[32*t+8 +: 8], blk[32*t+16 +: 8], blk[32*t+24 +: 8]};
      for (int t = 16; t < 64; t++)
         w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
              + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
      {h, g, f, e, d, c, b, a} = v;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {v[255:224] + h, v[223:192] + g, v[191:160] + f, v[159:128] + e,
              v[127:96] + d, v[95:64] + c, v[63:32] + b, v[31:0] + a};
   endfunction

   function automatic logic [511:0] hdr_blk(input logic [95:0] tail, input logic [31:0] n);
      logic [511:0] bl = '0;
      for (int i = 0; i < 12; i++) bl[8*i +: 8] = tail[8*i +: 8];
      for (int i = 0; i < 4; i++)  bl[8*(12+i) +: 8] = n[8*i +: 8];
      bl[8*16 +: 8] = 8'h80; bl[8*62 +: 8] = 8'h02; bl[8*63 +: 8] = 8'h80;
      return bl;
   endfunction

   function automatic logic [511:0] hash_blk(input logic [255:0] hv);
      logic [511:0] bl = '0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 4; j++) bl[8*(4*k+j) +: 8] = hv[32*k + 8*(3-j) +: 8];
      bl[8*32 +: 8] = 8'h80; bl[8*62 +: 8] = 8'h01; bl[8*63 +: 8] = 8'h00;
      return bl;
   endfunction

   function automatic logic model_hit(input logic [255:0] h2);
      logic [511:0] bl = hash_blk(h2);
`ifdef SHA_FEEDER_TARGET_EN
      return bl[255:0] <= target;
`else
      return (bl[255:0] != '0) && (h2[255:224] == 32'd0);
`endif
   endfunction

   // Behavioural sha256_chunk: garbage until the hash is valid in the LAT-th cycle.
   always @(posedge clk) begin
      if (core_start) begin
         lat       <= 1;
         pend      <= sha_compress(core_data, core_V);
         core_hash <= {8{32'hdeadbeef}};
      end else if (lat != 0 && lat < LAT-2) begin
         lat <= lat + 1;
      end else if (lat == LAT-2) begin
         lat       <= 0;
         core_hash <= pend;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (core_start) begin
            cs_cnt <= cs_cnt + 1;
            if (exp_core.size() == 0) chk("core_unexpected", 1, 0);
            else begin
               chk("core_data", core_data, exp_core[0].d);
               chk("core_V", core_V, exp_core[0].v);
               void'(exp_core.pop_front());
            end
         end
         if (result_valid) begin
            rv_cnt     <= rv_cnt + 1;
            rv_cyc     <= cyc;
            last_nonce <= result_nonce;
            if (exp_res.size() == 0) chk("res_unexpected", result_nonce, 0);
            else chk("res_nonce", result_nonce, exp_res.pop_front());
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   task automatic prep(input logic [31:0] s, input logic [31:0] e);
      logic [31:0]  n = s;
      logic [255:0] h1, h2;
      n_hits = 0;
      forever begin
         exp_core.push_back('{d: hdr_blk(tail_m, n), v: mid_m});
         h1 = sha_compress(hdr_blk(tail_m, n), mid_m);
         exp_core.push_back('{d: hash_blk(h1), v: IV});
         h2 = sha_compress(hash_blk(h1), IV);
         if (model_hit(h2)) begin exp_res.push_back(n); n_hits++; end
         if (n == e) break;
         n = n + 32'd1;
      end
   endtask

   task automatic go(input logic [31:0] s, input logic [31:0] e);
      @(negedge clk);
      midstate = mid_m; hdr_tail = tail_m; nonce_start = s; nonce_end = e; work_valid = 1'b1;
      @(posedge clk); #1;
      work_valid = 1'b0;
      acc = cyc;
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", work_ready, 0);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int d0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) begin ok = 1'b1; break; end
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   task automatic run(input logic [31:0] s, input logic [31:0] e, input int exp_lat, input bit poke);
      bit ok;
      prep(s, e);
      go(s, e);
      if (poke) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge clk); work_valid = 1'b1; nonce_start = s + 32'd100;
         end
         @(negedge clk); work_valid = 1'b0;
      end
      wait_done(exp_lat + 50, ok);
      if (ok) chk("latency", done_cyc - acc, exp_lat);
      chk("core_q_left", exp_core.size(), 0);
      chk("res_q_left", exp_res.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [639:0] gh;
      logic [511:0] blk0;
      int rv0, d0, c0;
`ifdef SHA_FEEDER_TARGET_EN
      logic [255:0] dig;
      logic [511:0] bl;
`endif
      reset = 1'b1; work_valid = 1'b0; abort = 1'b0; midstate = '0; hdr_tail = '0;
      nonce_start = '0; nonce_end = '0; target = '1;
      gh = GEN_HDR;
      for (int i = 0; i < 64; i++) blk0[8*i +: 8] = gh[639 - 8*i -: 8];
      for (int i = 0; i < 12; i++) tail_m[8*i +: 8] = gh[639 - 8*(64+i) -: 8];
      mid_m = sha_compress(blk0, IV);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", work_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_start", core_start, 0);
      chk("rst_data", core_data, 0);
      chk("rst_V", core_V, 0);
      reset = 1'b0;

      // Genesis range: single hit at 7C2BAC1D.
      rv0 = rv_cnt;
      run(32'h7C2BAC1A, 32'h7C2BAC1F, 6*NONCE_CYC, 1'b0);
      chk("genesis_hits", rv_cnt - rv0, 1);
      chk("genesis_nonce", last_nonce, GEN_NONCE);

      // Wrapping range with work_valid pokes while busy.
      rv0 = rv_cnt;
      run(32'hFFFFFFFE, 32'h00000001, 4*NONCE_CYC, 1'b1);
      chk("wrap_hits", rv_cnt - rv0, n_hits);

      // Single nonce that hits: result_valid together with done.
      rv0 = rv_cnt;
      run(GEN_NONCE, GEN_NONCE, NONCE_CYC, 1'b0);
      chk("single_hits", rv_cnt - rv0, 1);
      chk("hit_with_done", rv_cyc, done_cyc);
      chk("held_nonce", result_nonce, GEN_NONCE);

      // Reset during WAIT1.
      prep(GEN_NONCE, GEN_NONCE);
      go(GEN_NONCE, GEN_NONCE);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_ready", work_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_rv", result_valid, 0);
      chk("midrst_data", core_data, 0);
      chk("midrst_V", core_V, 0);
      chk("midrst_nonce", result_nonce, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_core.delete(); exp_res.delete();
      d0 = done_cnt; rv0 = rv_cnt;
      repeat (2*NONCE_CYC) @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt, d0);
      chk("midrst_no_rv", rv_cnt, rv0);

      // Abort in IDLE is ignored.
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("idle_abort_done", done, 0);
      chk("idle_abort_ready", work_ready, 1);

      // Abort during WAIT2 of a hitting nonce.
      prep(GEN_NONCE, GEN_NONCE);
      rv0 = rv_cnt; d0 = done_cnt; c0 = cs_cnt;
      go(GEN_NONCE, GEN_NONCE);
      for (int i = 0; i < 200 && cs_cnt < c0 + 2; i++) begin @(negedge clk); #1; end
      chk("abort_reach_wait2", cs_cnt - c0, 2);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("abort_done", done, 1);
      chk("abort_rv", result_valid, 0);
      chk("abort_ready", work_ready, 1);
      chk("abort_busy", busy, 0);
      exp_res.delete();
      chk("abort_core_q", exp_core.size(), 0);
      repeat (2*NONCE_CYC) @(negedge clk);
      #1;
      chk("abort_no_rv", rv_cnt - rv0, 0);
      chk("abort_one_done", done_cnt - d0, 1);

`ifdef SHA_FEEDER_TARGET_EN
      bl  = hash_blk(sha_compress(hash_blk(sha_compress(hdr_blk(tail_m, GEN_NONCE), mid_m)), IV));
      dig = bl[255:0];
      target = dig;
      rv0 = rv_cnt;
      run(GEN_NONCE, GEN_NONCE, NONCE_CYC, 1'b0);
      chk("tgt_eq_hits", rv_cnt - rv0, 1);
      target = dig - 256'd1;
      rv0 = rv_cnt;
      run(GEN_NONCE, GEN_NONCE, NONCE_CYC, 1'b0);
      chk("tgt_lt_hits", rv_cnt - rv0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
